// File: rtl/uart_fifo_pkg.sv
// uart_fifo_pkg: shared defaults and types for the UART byte FIFO.
package uart_fifo_pkg;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 2048;
    localparam int ADDR_W = $clog2(DEPTH);

    // Pointer carries one extra wrap bit above the RAM address.
    typedef logic [ADDR_W:0]   ptr_t;
    typedef logic [DATA_W-1:0] data_t;

endpackage

// File: rtl/uart_fifo_if.sv
// uart_fifo_if: producer/consumer handshake for the UART byte FIFO.
// UART_FIFO_ERR_EN adds the sticky overflow/underflow status bits.
interface uart_fifo_if;
    import uart_fifo_pkg::*;

    data_t din;
    logic  wr_en;
    logic  rd_en;
    logic  full;
    logic  empty;
    data_t dout;
`ifdef UART_FIFO_ERR_EN
    logic  overflow;
    logic  underflow;

    modport master (output din, wr_en, rd_en, input full, empty, dout, overflow, underflow);
    modport slave  (input din, wr_en, rd_en, output full, empty, dout, overflow, underflow);
`else
    modport master (output din, wr_en, rd_en, input full, empty, dout);
    modport slave  (input din, wr_en, rd_en, output full, empty, dout);
`endif

endinterface

// File: rtl/uart_fifo_ram.sv
// uart_fifo_ram: simple dual-port synchronous RAM, one write port and one
// registered read port. Storage is never cleared; only the read register resets.
module uart_fifo_ram
    import uart_fifo_pkg::*;
#(
    parameter int DW = DATA_W,
    parameter int AW = ADDR_W
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] rd_data_q, rd_data_d;

    // Write port: store the byte at the write address.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    // Read register holds its value unless a read is accepted.
    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) rd_data_d = mem[rd_addr];
    end

    // Read data register, cleared on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_data_q <= '0;
        else        rd_data_q <= rd_data_d;
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/uart_fifo.sv
// uart_fifo: single-clock byte FIFO with registered full/empty flags and
// registered read data. Define UART_FIFO_ERR_EN for sticky overflow/underflow.
module uart_fifo #(
    parameter int DATA_W = uart_fifo_pkg::DATA_W,
    parameter int DEPTH  = uart_fifo_pkg::DEPTH
) (
    input  logic        clk,
    input  logic        rst_n,
    uart_fifo_if.slave  bus
);

    localparam int ADDR_W = $clog2(DEPTH);
    typedef logic [ADDR_W:0]   lptr_t;
    typedef logic [DATA_W-1:0] ldata_t;

    lptr_t  wr_ptr_q, wr_ptr_d;
    lptr_t  rd_ptr_q, rd_ptr_d;
    logic   full_q, full_d;
    logic   empty_q, empty_d;
    logic   wr_acc, rd_acc;
    ldata_t dout;

    // Accept decisions use the registered flags; empty blocks reads (no
    // bypass) and full blocks writes, so the RAM never sees a same-address
    // read and write in one cycle.
    always_comb begin
        wr_acc   = bus.wr_en && !full_q;
        rd_acc   = bus.rd_en && !empty_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_acc) wr_ptr_d = wr_ptr_q + lptr_t'(1);
        if (rd_acc) rd_ptr_d = rd_ptr_q + lptr_t'(1);
        empty_d  = (wr_ptr_d == rd_ptr_d);
        full_d   = (wr_ptr_d[ADDR_W-1:0] == rd_ptr_d[ADDR_W-1:0]) &&
                   (wr_ptr_d[ADDR_W] != rd_ptr_d[ADDR_W]);
    end

    // Pointer and flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    uart_fifo_ram #(
        .DW (DATA_W),
        .AW (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr_q[ADDR_W-1:0]),
        .wr_data (bus.din),
        .rd_en   (rd_acc),
        .rd_addr (rd_ptr_q[ADDR_W-1:0]),
        .rd_data (dout)
    );

    assign bus.dout  = dout;
    assign bus.full  = full_q;
    assign bus.empty = empty_q;

`ifdef UART_FIFO_ERR_EN
    logic ovf_q, ovf_d;
    logic unf_q, unf_d;

    // Any dropped access sets its status bit until reset.
    always_comb begin
        ovf_d = ovf_q | (bus.wr_en & full_q);
        unf_d = unf_q | (bus.rd_en & empty_q);
    end

    // Sticky error registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign bus.overflow  = ovf_q;
    assign bus.underflow = unf_q;
`endif

endmodule

// File: tb/tb_uart_fifo.sv
// tb_uart_fifo: directed scenarios plus randomized traffic, all checked every
// cycle against a queue-based model of the FIFO.
module tb_uart_fifo;
    import uart_fifo_pkg::*;

    localparam int D = DEPTH;

    logic clk = 1'b0;
    logic rst_n;

    uart_fifo_if bus ();

    uart_fifo dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // ---------------- behavioural model ----------------
    byte unsigned q[$];
    logic [7:0]   m_dout = 8'h00;
    bit           m_ovf  = 1'b0;
    bit           m_unf  = 1'b0;
    bit           m_wa, m_ra;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            m_dout = 8'h00;
            m_ovf  = 1'b0;
            m_unf  = 1'b0;
        end else begin
            m_wa = bus.wr_en && (q.size() < D);
            m_ra = bus.rd_en && (q.size() > 0);
            if (bus.wr_en && q.size() == D) m_ovf = 1'b1;
            if (bus.rd_en && q.size() == 0) m_unf = 1'b1;
            if (m_ra) m_dout = q.pop_front();
            if (m_wa) q.push_back(bus.din);
        end
    end

    // Compare process: outputs against the model on every falling edge.
    always @(negedge clk) begin
        chk("empty", bus.empty, (q.size() == 0));
        chk("full",  bus.full,  (q.size() == D));
        chk("dout",  bus.dout,  m_dout);
`ifdef UART_FIFO_ERR_EN
        chk("overflow",  bus.overflow,  m_ovf);
        chk("underflow", bus.underflow, m_unf);
`endif
    end

    // One transfer cycle: drive after a falling edge, return at the next one.
    task automatic op(input bit w, input bit r, input logic [7:0] d);
        bus.wr_en = w;
        bus.rd_en = r;
        bus.din   = d;
        @(negedge clk);
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
    endtask

    initial begin
        logic [7:0] exp5 [5];
        int wp, rp;
        exp5 = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h13};
        bus.din   = 8'h00;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        rst_n     = 1'b0;

        // Reset for 1000 ns, then five idle cycles at reset values.
        #1000;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("rst_empty", bus.empty, 1);
            chk("rst_full",  bus.full,  0);
            chk("rst_dout",  bus.dout,  0);
        end

        // Three writes, three reads with one-cycle latency.
        op(1, 0, 8'h10); op(1, 0, 8'h11); op(1, 0, 8'h12);
        chk("w3_empty", bus.empty, 0);
        op(0, 1, 8'h00); chk("rd0", bus.dout, 8'h10);
        op(0, 1, 8'h00); chk("rd1", bus.dout, 8'h11);
        op(0, 1, 8'h00); chk("rd2", bus.dout, 8'h12);
        chk("r3_empty", bus.empty, 1);

        // Five reads with four stored: last read ignored, dout holds.
        for (int i = 0; i < 4; i++) op(1, 0, 8'(8'h10 + i));
        for (int i = 0; i < 5; i++) begin
            op(0, 1, 8'h00);
            chk("rd5", bus.dout, exp5[i]);
        end
        chk("rd5_empty", bus.empty, 1);
`ifdef UART_FIFO_ERR_EN
        chk("underflow_set", bus.underflow, 1);
        chk("overflow_clr",  bus.overflow,  0);
`endif

        // Fill to full, extra write dropped.
        for (int i = 0; i < D - 1; i++) op(1, 0, 8'hAB);
        chk("almost_full", bus.full, 0);
        op(1, 0, 8'h11);
        chk("full_set", bus.full, 1);
        op(1, 0, 8'h55);
        chk("full_hold", bus.full, 1);
        chk("full_dout", bus.dout, 8'h13);
`ifdef UART_FIFO_ERR_EN
        chk("overflow_set", bus.overflow, 1);
`endif

        // Full with read+write: read wins, write dropped.
        op(1, 1, 8'h66);
        chk("fullrw_dout", bus.dout, 8'hAB);
        chk("fullrw_full", bus.full, 0);

        // Drain the rest: 2046 x 0xAB then 0x11.
        for (int i = 0; i < D - 2; i++) begin
            op(0, 1, 8'h00);
            chk("drain_ab", bus.dout, 8'hAB);
        end
        op(0, 1, 8'h00);
        chk("drain_last", bus.dout, 8'h11);
        chk("drain_empty", bus.empty, 1);

        // Write to empty with rd_en in the same cycle: no bypass.
        op(1, 1, 8'h77);
        chk("nobypass_dout",  bus.dout,  8'h11);
        chk("nobypass_empty", bus.empty, 0);
        op(0, 1, 8'h00);
        chk("nobypass_rd", bus.dout, 8'h77);

        // 100 entries stored, reset mid-cycle takes effect immediately.
        for (int i = 0; i < 100; i++) op(1, 0, 8'($urandom));
        op(0, 1, 8'h00);
        #3 rst_n = 1'b0;
        #1;
        chk("midrst_empty", bus.empty, 1);
        chk("midrst_full",  bus.full,  0);
        chk("midrst_dout",  bus.dout,  0);
`ifdef UART_FIFO_ERR_EN
        chk("midrst_ovf", bus.overflow, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic in phases of different read/write bias.
        for (int ph = 0; ph < 6; ph++) begin
            wp = (ph % 3 == 0) ? 80 : (ph % 3 == 1) ? 50 : 25;
            rp = (ph % 3 == 0) ? 20 : (ph % 3 == 1) ? 50 : 75;
            repeat (700) op($urandom_range(0, 99) < wp, $urandom_range(0, 99) < rp, 8'($urandom));
            if (ph == 2) begin
                #2 rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
